// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key inputs and conditioned key outputs of the debouncer
interface key_debounce_if #(
    parameter int N = 4
);
    logic [N-1:0] KEY_IN;
    logic [N-1:0] KEY_OUT;
    logic [N-1:0] KEY_RISE;
    logic [N-1:0] KEY_FALL;
    modport master (output KEY_IN, input KEY_OUT, KEY_RISE, KEY_FALL);
    modport slave (input KEY_IN, output KEY_OUT, KEY_RISE, KEY_FALL);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-channel synchroniser, stability-counter FSM and edge pulses
module key_debounce #(
    parameter int N          = 4,
    parameter int STABLE     = 1000000,
    parameter int CNT_W      = 20,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic          CLK,
    input logic          CLR,
    key_debounce_if.slave bus
);
    typedef enum logic [1:0] {IDLE0, WAIT1, IDLE1, WAIT0} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
    logic [N-1:0] out_v, rise_v, fall_v;
    for (genvar i = 0; i < N; i++) begin : ch
        logic             s1, s2;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d, rise_q, rise_d, fall_q, fall_d;
        // two-flop synchroniser on the polarity-corrected raw key
        always_ff @(posedge CLK or posedge CLR) begin
            if (CLR) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= bus.KEY_IN[i] ^ ACTIVE_LOW;
                s2 <= s1;
            end
        end
        // state, stability counter and registered outputs
        always_ff @(posedge CLK or posedge CLR) begin
            if (CLR) begin
                state_q <= IDLE0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end
        // accept a new level only after STABLE consecutive disagreeing samples
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            out_d   = out_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                IDLE0: begin
                    state_d = s2 ? WAIT1 : IDLE0;
                    cnt_d   = s2 ? CNT_W'(1) : '0;
                end
                WAIT1: begin
                    if (!s2) begin
                        state_d = IDLE0;
                    end else if (cnt_q == LAST) begin
                        state_d = IDLE1;
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE1: begin
                    state_d = s2 ? IDLE1 : WAIT0;
                    cnt_d   = s2 ? '0 : CNT_W'(1);
                end
                default: begin
                    if (s2) begin
                        state_d = IDLE1;
                    end else if (cnt_q == LAST) begin
                        state_d = IDLE0;
                        out_d   = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
        assign out_v[i]  = out_q;
        assign rise_v[i] = rise_q;
        assign fall_v[i] = fall_q;
    end
    assign bus.KEY_OUT  = out_v;
    assign bus.KEY_RISE = rise_v;
    assign bus.KEY_FALL = fall_v;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scenario tasks checked against a run-length reference model
module tb_key_debounce;
    localparam int N = 2;
    localparam int STABLE = 4;
    logic CLK = 1'b0;
    logic CLR = 1'b1;
    logic [N-1:0] key = '0;
    int checks = 0;
    int passes = 0;
    key_debounce_if #(.N(N)) i0 ();
    key_debounce_if #(.N(N)) i1 ();
    assign i0.KEY_IN = key;
    assign i1.KEY_IN = ~key;
    key_debounce #(.N(N), .STABLE(STABLE), .CNT_W(3), .ACTIVE_LOW(1'b0)) u0 (.CLK(CLK), .CLR(CLR), .bus(i0));
    key_debounce #(.N(N), .STABLE(STABLE), .CNT_W(3), .ACTIVE_LOW(1'b1)) u1 (.CLK(CLK), .CLR(CLR), .bus(i1));
    always #5 CLK = ~CLK;

    // reference: a level flips once the synchronised key has disagreed with it for STABLE edges in a row
    logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    int m_run [N];
    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_s1 <= '0; m_s2 <= '0; m_out <= '0; m_rise <= '0; m_fall <= '0;
            for (int c = 0; c < N; c++) m_run[c] <= 0;
        end else begin
            m_s1 <= key;
            m_s2 <= m_s1;
            for (int c = 0; c < N; c++) begin
                m_rise[c] <= 1'b0;
                m_fall[c] <= 1'b0;
                if (m_s2[c] == m_out[c]) m_run[c] <= 0;
                else if (m_run[c] + 1 == STABLE) begin
                    m_out[c] <= ~m_out[c];
                    m_rise[c] <= ~m_out[c];
                    m_fall[c] <= m_out[c];
                    m_run[c] <= 0;
                end else m_run[c] <= m_run[c] + 1;
            end
        end
    end

    wire [3*N-1:0] o0 = {i0.KEY_OUT, i0.KEY_RISE, i0.KEY_FALL};
    wire [3*N-1:0] o1 = {i1.KEY_OUT, i1.KEY_RISE, i1.KEY_FALL};
    wire [3*N-1:0] om = {m_out, m_rise, m_fall};

    task automatic test_reset();
        CLR = 1'b1; key = 2'b00;
        #1;
        if ({o0, o1} !== 12'h0) $display("FAIL reset_idle got %b/%b exp 0", o0, o1); else passes++;
        checks++;
        key = 2'b11;
        repeat (3) begin
            @(posedge CLK); #1;
            if ({o0, o1} !== 12'h0) $display("FAIL reset_held got %b/%b exp 0", o0, o1); else passes++;
            checks++;
        end
        key = 2'b00; CLR = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            if ({o0, o1} !== {om, om}) $display("FAIL reset_release got %b/%b exp %b", o0, o1, om); else passes++;
            checks++;
        end
    endtask

    task automatic test_clean_step();
        key = 2'b01;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLK); #1;
            if ({o0, o1} !== {2{1'b0, e >= 5, 1'b0, e == 5, 2'b00}} || o0 !== om)
                $display("FAIL clean_step e=%0d got %b/%b exp %b", e, o0, o1, {1'b0, e >= 5, 1'b0, e == 5, 2'b00});
            else passes++;
            checks++;
        end
    endtask

    task automatic test_bounce();
        int pat [7] = '{1, 1, 1, 0, 1, 1, 0};
        int rises = 0;
        key = 2'b00;
        repeat (8) begin @(posedge CLK); #1; end
        for (int e = 0; e < 14; e++) begin
            key[0] = (e < 7) ? pat[e][0] : 1'b0;
            @(posedge CLK); #1;
            if (o0[4] !== 1'b0 || o0[2] !== 1'b0 || o0[0] !== 1'b0 || o0 !== om)
                $display("FAIL bounce e=%0d got %b exp %b", e, o0, om);
            else passes++;
            checks++;
        end
        key[0] = 1'b1;
        repeat (10) begin
            @(posedge CLK); #1;
            rises += int'(i0.KEY_RISE[0]);
            if ({o0, o1} !== {om, om}) $display("FAIL bounce_settle got %b/%b exp %b", o0, o1, om); else passes++;
            checks++;
        end
        if (rises !== 1) $display("FAIL bounce_rise_count got %0d exp 1", rises); else passes++;
        checks++;
    endtask

    task automatic test_release();
        key = 2'b10;
        repeat (10) begin @(posedge CLK); #1; end
        key = 2'b00;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLK); #1;
            if ({o0, o1} !== {2{e < 5, 1'b0, 2'b00, e == 5, 1'b0}})
                $display("FAIL release e=%0d got %b/%b exp %b", e, o0, o1, {e < 5, 1'b0, 2'b00, e == 5, 1'b0});
            else passes++;
            checks++;
        end
    endtask

    task automatic test_active_low();
        key = 2'b00;
        repeat (3) begin @(posedge CLK); #1; end
        if (i1.KEY_IN !== 2'b11 || o1 !== 6'b0) $display("FAIL al_idle got in=%b out=%b exp in=11 out=0", i1.KEY_IN, o1); else passes++;
        checks++;
        key[0] = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(posedge CLK); #1;
            if (o1 !== {1'b0, e >= 5, 1'b0, e == 5, 2'b00}) $display("FAIL al_press e=%0d got %b exp %b", e, o1, {1'b0, e >= 5, 1'b0, e == 5, 2'b00});
            else passes++;
            checks++;
        end
    endtask

    task automatic test_clr_mid_wait();
        key = 2'b00;
        repeat (8) begin @(posedge CLK); #1; end
        key = 2'b01;
        repeat (4) begin @(posedge CLK); #1; end
        CLR = 1'b1;
        #1;
        if ({o0, o1} !== 12'h0) $display("FAIL clr_wait_assert got %b/%b exp 0", o0, o1); else passes++;
        checks++;
        @(posedge CLK); #1;
        CLR = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLK); #1;
            if ({o0, o1} !== {2{1'b0, e >= 5, 1'b0, e == 5, 2'b00}} || o0 !== om)
                $display("FAIL clr_wait e=%0d got %b/%b exp %b", e, o0, o1, {1'b0, e >= 5, 1'b0, e == 5, 2'b00});
            else passes++;
            checks++;
        end
    endtask

    task automatic test_toggle();
        key = 2'b00;
        repeat (8) begin @(posedge CLK); #1; end
        for (int e = 0; e < 20; e++) begin
            key = ~key;
            @(posedge CLK); #1;
            if ({o0, o1} !== 12'h0) $display("FAIL toggle e=%0d got %b/%b exp 0", e, o0, o1); else passes++;
            checks++;
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 80; b++) begin
            int len = $urandom_range(1, 8);
            logic [1:0] v = 2'($urandom);
            key = ($urandom_range(0, 3) == 0) ? {2{v[0]}} : v;
            repeat (len) begin
                @(posedge CLK); #1;
                if ({o0, o1} !== {om, om}) $display("FAIL random b=%0d got %b/%b exp %b", b, o0, o1, om); else passes++;
                checks++;
                if (key[0] == key[1] && i0.KEY_OUT[0] == i0.KEY_OUT[1] && m_run[0] == m_run[1]) begin
                    if ({i0.KEY_RISE[0], i0.KEY_FALL[0]} !== {i0.KEY_RISE[1], i0.KEY_FALL[1]} && {m_rise[0], m_fall[0]} === {m_rise[1], m_fall[1]})
                        $display("FAIL random_twin b=%0d got %b exp %b", b, o0, om);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_release();
        test_active_low();
        test_clr_mid_wait();
        test_toggle();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
